frame_scheduler: RTL

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

---
 rtl/frame_scheduler.sv | 103 ++++++++++
 1 files changed

// File: rtl/frame_scheduler.sv
// Double-buffered frame scheduler. It starts the drawing engine on each frame tick
// and commits engine pixels into the back buffer. Buffers swap on the tick after drawing completes.
module frame_scheduler #(
    parameter int W = 640,
    parameter int H = 480
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        draw_done,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic [7:0]  draw_color,
    input  logic        mem_ready,
    output logic [1:0]  frame_clk_edge,
    output logic        buffer_using,
    output logic        wr_en,
    output logic        mem_we,
    output logic [19:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic [7:0]  overrun_cnt
);

    typedef enum logic [1:0] {IDLE, START, DRAW, WAIT_SWAP} state_t;

    state_t      state, state_nxt;
    logic        sync1, sync2, sync_prev;
    logic        done_prev;
    logic        back_sel;
    logic        tick, done_rise, in_range;
    logic [18:0] offset;

    assign tick      = sync2 & ~sync_prev;
    assign done_rise = draw_done & ~done_prev;
    assign in_range  = ({1'b0, draw_x} < 11'(W)) && ({1'b0, draw_y} < 11'(H));
    assign offset    = 19'(draw_y) * 19'(W) + 19'(draw_x);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
            done_prev <= 1'b0;
        end else begin
            sync1     <= frame_clk;
            sync2     <= sync1;
            sync_prev <= sync2;
            done_prev <= draw_done;
        end
    end

    always_comb begin
        state_nxt      = state;
        frame_clk_edge = 2'b00;
        wr_en          = 1'b0;
        case (state)
            IDLE:      if (tick) state_nxt = START;
            START: begin
                frame_clk_edge = 2'b01;
                state_nxt      = DRAW;
            end
            DRAW: begin
                wr_en = mem_ready;
                if (done_rise) state_nxt = WAIT_SWAP;
            end
            WAIT_SWAP: if (tick) state_nxt = START;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            back_sel     <= 1'b1;
            buffer_using <= 1'b0;
            overrun_cnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == START)
                back_sel <= ~buffer_using;
            if (state == WAIT_SWAP && tick)
                buffer_using <= back_sel;
            // A tick during DRAW is a dropped frame, even if drawing finishes that same cycle.
            if (state == DRAW && tick && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mem_we   <= 1'b0;
            mem_addr <= 20'd0;
            mem_data <= 8'd0;
        end else begin
            mem_we <= wr_en && in_range;
            if (wr_en && in_range) begin
                mem_addr <= {back_sel, offset};
                mem_data <= draw_color;
            end
        end
    end

endmodule
